// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
//
// Memory end of the CPU core's inst/data SRAM interface. The core drives
// en / we[3:0] / addr / wdata. Read data comes back exactly one cycle after the
// request, with no handshake. Writes use per-byte enables and are read-first:
// the write edge also returns the old word contents. Accesses outside
// [BASE_ADDR, BASE_ADDR + 4*DEPTH) are dropped and return OOR_RDATA. They also
// set a sticky error flag, which captures the first offending byte address.
// Read and write access counters are kept for debug.
//
// Parameters:
//   DEPTH      number of 32-bit words (power of two, >= 2)
//   BASE_ADDR  byte address of word 0 (4-byte aligned)
//   OOR_RDATA  read data returned for out-of-range accesses
//
// Ports:
//   clk         in   1   clock, all state updates on the rising edge
//   resetn      in   1   asynchronous active-low reset
//   sram_en     in   1   access request this cycle
//   sram_we     in   4   byte write enables (0 = read)
//   sram_addr   in  32   byte address, bits [1:0] ignored
//   sram_wdata  in  32   write data
//   sram_rdata  out 32   registered read data
//   rd_cnt      out 32   accepted read accesses (wrapping)
//   wr_cnt      out 32   accepted write accesses (wrapping)
//   err         out  1   sticky out-of-range flag
//   err_addr    out 32   byte address of the first out-of-range access
// -----------------------------------------------------------------------------
module sram_responder #(
  parameter int unsigned DEPTH     = 65536,
  parameter logic [31:0] BASE_ADDR = 32'h1C00_0000,
  parameter logic [31:0] OOR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // ---------------------------------------------------------------------------
  // Address decode. BASE_ADDR is word aligned, so the whole decode can be done
  // on word addresses. The byte offset bits are intentionally unused.
  // ---------------------------------------------------------------------------
  logic [29:0]   word_off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          is_write;
  logic          unused_byte_off;

  assign unused_byte_off = ^sram_addr[1:0];
  assign word_off        = sram_addr[31:2] - BASE_ADDR[31:2];
  // The full offset is compared, not just the index bits. Without this, an
  // address just past the top would alias onto the low words.
  assign in_range        = (sram_addr[31:2] >= BASE_ADDR[31:2]) &&
                           ({2'b00, word_off} < DEPTH);
  assign idx             = word_off[AW-1:0];
  assign is_write        = |sram_we;

  // ---------------------------------------------------------------------------
  // Storage: one registered read port and per-byte write enables, the shape
  // that block-RAM inference expects.
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q [DEPTH];

  // NOTE: the array has no reset branch on purpose. A reset loop over every
  // word would prevent block-RAM inference, and its contents must survive reset.
  always_ff @(posedge clk) begin
    if (resetn && sram_en && is_write && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_we[b]) mem_q[idx][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read data register. A write edge also samples the pre-write word
  // (read-first), because the array update above lands on the same edge.
  // ---------------------------------------------------------------------------
  logic [31:0] rdata_q;

  // NOTE: sequential state is always assigned with <=, so every flop samples
  // the values that existed before the edge, whatever order the blocks run in.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= '0;
    end else if (sram_en) begin
      rdata_q <= in_range ? mem_q[idx] : OOR_RDATA;
    end
  end

  // ---------------------------------------------------------------------------
  // Debug counters and sticky error capture.
  // ---------------------------------------------------------------------------
  logic [31:0] rd_cnt_q,   rd_cnt_d;
  logic [31:0] wr_cnt_q,   wr_cnt_d;
  logic        err_q,      err_d;
  logic [31:0] err_addr_q, err_addr_d;

  // NOTE: every combinational output gets a default first. Then no path
  // leaves a value unassigned, and no latch is inferred.
  always_comb begin
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (sram_en) begin
      if (is_write) wr_cnt_d = wr_cnt_q + 32'd1;
      else          rd_cnt_d = rd_cnt_q + 32'd1;
      if (!in_range) begin
        err_d = 1'b1;
        // Only the first offending address is kept until the next reset.
        if (!err_q) err_addr_d = sram_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign sram_rdata = rdata_q;
  assign rd_cnt     = rd_cnt_q;
  assign wr_cnt     = wr_cnt_q;
  assign err        = err_q;
  assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_responder
//
// Self-checking bench for sram_responder. The reference model holds memory as
// individual bytes in an associative array keyed by byte offset. It computes
// range, counters and error capture with plain arithmetic on byte addresses.
// A small DEPTH keeps the out-of-range boundaries easy to reach.
// -----------------------------------------------------------------------------
module tb_sram_responder;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1C00_0000;
  localparam logic [31:0] OOR   = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sram_en = 1'b0;
  logic [3:0]  sram_we = '0;
  logic [31:0] sram_addr = '0;
  logic [31:0] sram_wdata = '0;
  logic [31:0] sram_rdata;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic        err;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  sram_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .OOR_RDATA(OOR)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt),
    .err        (err),
    .err_addr   (err_addr)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0]  m_bytes [longint];   // key = byte offset from BASE
  logic [31:0] m_rdata;
  bit          m_rdata_known;
  logic [31:0] m_rd, m_wr, m_err_addr;
  bit          m_err;

  task automatic model_reset();
    m_rdata = '0; m_rdata_known = 1'b1;
    m_rd = '0; m_wr = '0; m_err = 1'b0; m_err_addr = '0;
  endtask

  task automatic model_access(input logic en, input logic [3:0] we,
                              input logic [31:0] addr, input logic [31:0] wdata);
    longint a    = longint'(addr);
    longint b    = longint'(BASE);
    longint word = (a - b) / 4;
    bit     in   = (a >= b) && (word < longint'(DEPTH));
    if (!en) return;
    if (we == 4'h0) m_rd = m_rd + 1; else m_wr = m_wr + 1;
    if (in) begin
      m_rdata_known = 1'b1;
      for (int l = 0; l < 4; l++) begin
        if (m_bytes.exists(word*4 + l)) m_rdata[8*l +: 8] = m_bytes[word*4 + l];
        else m_rdata_known = 1'b0;
      end
      for (int l = 0; l < 4; l++)
        if (we[l]) m_bytes[word*4 + l] = wdata[8*l +: 8];
    end else begin
      m_rdata = OOR; m_rdata_known = 1'b1;
      if (!m_err) m_err_addr = addr;
      m_err = 1'b1;
    end
  endtask

  // One access occupying exactly one clock edge. Inputs change on the falling
  // edge, outputs are sampled 1 ns after the rising edge.
  task automatic access(input logic en, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    sram_en = en; sram_we = we; sram_addr = addr; sram_wdata = wdata;
    @(posedge clk);
    #1;
    model_access(en, we, addr, wdata);
    sram_en = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    access(1'b1, 4'hF, BASE, 32'h0280_0C0C);  // preload word 0
    @(negedge clk);
    resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (sram_rdata !== 32'h0 || rd_cnt !== 32'h0 || wr_cnt !== 32'h0 ||
        err !== 1'b0 || err_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: rdata=%h rd=%h wr=%h err=%b err_addr=%h, required all zero",
               sram_rdata, rd_cnt, wr_cnt, err, err_addr);
    end
    @(negedge clk);
    resetn = 1'b1;
    access(1'b1, 4'h0, BASE, 32'h0);
    checks++;
    if (sram_rdata !== 32'h0280_0C0C) begin
      errors++; $display("FAIL reset_read_word0: got %h required 02800c0c", sram_rdata);
    end
    checks++;
    if (rd_cnt !== 32'd1) begin
      errors++; $display("FAIL reset_rd_cnt: got %0d required 1", rd_cnt);
    end
  endtask

  task automatic test_partial_write();
    access(1'b1, 4'hF,    BASE + 8, 32'h1122_3344);
    access(1'b1, 4'b0101, BASE + 8, 32'hAABB_CCDD);
    access(1'b1, 4'h0,    BASE + 8, 32'h0);
    checks++;
    if (sram_rdata !== 32'h11BB_33DD) begin
      errors++; $display("FAIL partial_rdata: got %h required 11bb33dd", sram_rdata);
    end
    checks++;
    if (wr_cnt !== 32'd2) begin
      errors++; $display("FAIL partial_wr_cnt: got %0d required 2", wr_cnt);
    end
  endtask

  task automatic test_read_first();
    access(1'b1, 4'hF, BASE + 4, 32'h0);
    access(1'b1, 4'hF, BASE + 4, 32'hCAFE_F00D);
    checks++;
    if (sram_rdata !== 32'h0) begin
      errors++; $display("FAIL read_first_old: got %h required 00000000", sram_rdata);
    end
    access(1'b1, 4'h0, BASE + 4, 32'h0);   // back-to-back read after write
    checks++;
    if (sram_rdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL read_after_write: got %h required cafef00d", sram_rdata);
    end
  endtask

  task automatic test_out_of_range();
    access(1'b1, 4'h0, BASE - 4, 32'h0);
    checks++;
    if (sram_rdata !== OOR || err !== 1'b1 || err_addr !== BASE - 4) begin
      errors++;
      $display("FAIL oor_read: rdata=%h err=%b err_addr=%h, required %h 1 %h",
               sram_rdata, err, err_addr, OOR, BASE - 4);
    end
    access(1'b1, 4'hF, BASE + 4*DEPTH, 32'h1234_5678);
    checks++;
    if (sram_rdata !== OOR || err !== 1'b1 || err_addr !== BASE - 4) begin
      errors++;
      $display("FAIL oor_write: rdata=%h err=%b err_addr=%h, required %h 1 %h",
               sram_rdata, err, err_addr, OOR, BASE - 4);
    end
    // The write just past the top must not have aliased onto word 0.
    access(1'b1, 4'h0, BASE, 32'h0);
    checks++;
    if (sram_rdata !== 32'h0280_0C0C) begin
      errors++; $display("FAIL oor_no_alias: got %h required 02800c0c", sram_rdata);
    end
    // The last in-range word must still work.
    access(1'b1, 4'hF, BASE + 4*(DEPTH-1), 32'h7777_0001);
    access(1'b1, 4'h0, BASE + 4*(DEPTH-1), 32'h0);
    checks++;
    if (sram_rdata !== 32'h7777_0001 || err_addr !== BASE - 4) begin
      errors++;
      $display("FAIL top_word: rdata=%h err_addr=%h required 77770001 %h",
               sram_rdata, err_addr, BASE - 4);
    end
  endtask

  task automatic test_idle();
    logic [31:0] rd0, wr0;
    access(1'b1, 4'hF, BASE + 12, 32'h5555_AAAA);
    access(1'b1, 4'h0, BASE + 12, 32'h0);
    rd0 = m_rd; wr0 = m_wr;
    for (int i = 0; i < 5; i++) begin
      access(1'b0, 4'($urandom), $urandom, $urandom);
      checks++;
      if (sram_rdata !== 32'h5555_AAAA || rd_cnt !== rd0 || wr_cnt !== wr0) begin
        errors++;
        $display("FAIL idle_hold[%0d]: rdata=%h rd=%0d wr=%0d required 5555aaaa %0d %0d",
                 i, sram_rdata, rd_cnt, wr_cnt, rd0, wr0);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [3:0]  we;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0:       addr = BASE + 4*DEPTH + 4*$urandom_range(0, 7);
        1:       addr = BASE - 4 - 4*$urandom_range(0, 7);
        default: addr = BASE + 4*$urandom_range(0, DEPTH-1);
      endcase
      addr[1:0] = 2'($urandom);
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      access($urandom_range(0, 5) != 0, we, addr, $urandom);
      checks++;
      if (rd_cnt !== m_rd || wr_cnt !== m_wr || err !== m_err || err_addr !== m_err_addr ||
          (m_rdata_known && sram_rdata !== m_rdata)) begin
        errors++;
        $display("FAIL random[%0d]: rdata=%h rd=%0d wr=%0d err=%b ea=%h required %h(known=%0b) %0d %0d %b %h",
                 i, sram_rdata, rd_cnt, wr_cnt, err, err_addr,
                 m_rdata, m_rdata_known, m_rd, m_wr, m_err, m_err_addr);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    access(1'b1, 4'hF, BASE + 20, 32'h600D_F00D);
    access(1'b1, 4'h0, BASE - 8, 32'h0);
    for (int i = 0; i < 6; i++) access(1'b1, 4'h0, BASE + 20, 32'h0);
    checks++;
    if (rd_cnt !== 32'd7 || err !== 1'b1) begin
      errors++; $display("FAIL pre_reset_state: rd=%0d err=%b required 7 1", rd_cnt, err);
    end
    // Assert reset between edges. The outputs must clear without a clock edge.
    @(posedge clk);
    #3;
    resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (sram_rdata !== 32'h0 || rd_cnt !== 32'h0 || wr_cnt !== 32'h0 ||
        err !== 1'b0 || err_addr !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: rdata=%h rd=%h wr=%h err=%b err_addr=%h, required all zero",
               sram_rdata, rd_cnt, wr_cnt, err, err_addr);
    end
    @(negedge clk);
    resetn = 1'b1;
    access(1'b1, 4'h0, BASE + 20, 32'h0);
    checks++;
    if (sram_rdata !== 32'h600D_F00D || rd_cnt !== 32'd1) begin
      errors++;
      $display("FAIL mem_survives_reset: rdata=%h rd=%0d required 600df00d 1", sram_rdata, rd_cnt);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_partial_write();
    test_read_first();
    test_out_of_range();
    test_idle();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
